// File: rtl/mdio_pkg.sv
// Shared constants, field widths and FSM encoding for the Clause-22 MDIO initiator.
package mdio_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam int unsigned PHYAD_W = 5;
  localparam int unsigned REGAD_W = 5;
  localparam int unsigned DATA_W  = 16;

  typedef logic [3:0] mdio_state_t;

  localparam mdio_state_t StIdle  = 4'd0;
  localparam mdio_state_t StPre   = 4'd1;
  localparam mdio_state_t StSt    = 4'd2;
  localparam mdio_state_t StOp    = 4'd3;
  localparam mdio_state_t StPhyad = 4'd4;
  localparam mdio_state_t StRegad = 4'd5;
  localparam mdio_state_t StTa    = 4'd6;
  localparam mdio_state_t StData  = 4'd7;
  localparam mdio_state_t StDone  = 4'd8;
  localparam mdio_state_t StGap   = 4'd9;

  // Field order after the preamble.
  function automatic mdio_state_t mdio_next_state(input mdio_state_t st);
    mdio_state_t nxt;
    case (st)
      StPre:   nxt = StSt;
      StSt:    nxt = StOp;
      StOp:    nxt = StPhyad;
      StPhyad: nxt = StRegad;
      StRegad: nxt = StTa;
      StTa:    nxt = StData;
      StData:  nxt = StDone;
      StDone:  nxt = StGap;
      default: nxt = StIdle;
    endcase
    return nxt;
  endfunction

  // Index of the last bit of each fixed-length field; the preamble is parameterised.
  function automatic logic [4:0] mdio_field_last(input mdio_state_t st);
    logic [4:0] last;
    case (st)
      StSt:    last = 5'd1;
      StOp:    last = 5'd1;
      StPhyad: last = 5'(PHYAD_W - 1);
      StRegad: last = 5'(REGAD_W - 1);
      StTa:    last = 5'd1;
      StData:  last = 5'(DATA_W - 1);
      default: last = 5'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/mdio_master_if.sv
// Command/response handshake between a host and the MDIO initiator.
interface mdio_master_if;
  import mdio_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_rd;
  logic [PHYAD_W-1:0] cmd_phy_addr;
  logic [REGAD_W-1:0] cmd_reg_addr;
  logic [DATA_W-1:0]  cmd_wdata;
  logic               rsp_valid;
  logic [DATA_W-1:0]  rsp_rdata;
  logic               rsp_err;
  logic               busy;

  modport master (
    output cmd_valid, cmd_rd, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_rd, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/mdio_clk_gen.sv
// MDC divider: each bit period is MDC_DIV cycles low then MDC_DIV cycles high.
// fall_tick marks the last cycle of a period, rise_tick the first high cycle (sample point).
module mdio_clk_gen #(
  parameter int unsigned MDC_DIV = 10
) (
  input  logic clk_200m,
  input  logic rst_200m,
  input  logic en,
  input  logic hold,
  output logic mdc,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int unsigned CntW = $clog2(2 * MDC_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(2 * MDC_DIV - 1);
  localparam logic [CntW-1:0] CntHigh = CntW'(MDC_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mdc_q, mdc_d;

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != CntLast)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Registered so the pad never sees a glitch or a short high phase.
    mdc_d = en && !hold && (cnt_d >= CntHigh);
  end

  always_ff @(posedge clk_200m or posedge rst_200m) begin
    if (rst_200m) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc       = mdc_q;
  assign fall_tick = en && (cnt_q == CntLast);
  assign rise_tick = en && (cnt_q == CntHigh);

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO management initiator: serialises register commands into MDC/MDIO frames.
// Optional MDIO_MASTER_TA_CHECK_EN flags reads whose responder leaves the second TA bit high.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int unsigned MDC_DIV = 10,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic         clk_200m,
  input  logic         rst_200m,
  mdio_master_if.slave host,
  output logic         mdc,
  output logic         mdio_out,
  output logic         mdio_oen,
  input  logic         mdio_in
);

  localparam logic [4:0] PreLast = 5'(PRE_LEN - 1);

  mdio_state_t       state_q, state_d;
  logic [4:0]        fcnt_q, fcnt_d;
  logic [31:0]       sr_q, sr_d;
  logic              rd_q, rd_d;
  logic              out_q, out_d;
  logic              oen_q, oen_d;
  logic [1:0]        sync_q;
  logic [DATA_W-1:0] rdata_sh_q, rdata_sh_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic       accept;
  logic       fall_tick, rise_tick;
  logic       clk_en, clk_hold;
  logic       frame_end;
  logic       release_nxt;
  logic [4:0] field_last;

  assign host.cmd_ready = (state_q == StIdle);
  assign host.busy      = !host.cmd_ready;
  assign host.rsp_valid = (state_q == StDone);
  assign host.rsp_rdata = rsp_rdata_q;

  assign accept     = host.cmd_valid && host.cmd_ready;
  assign clk_en     = (state_q != StIdle);
  assign clk_hold   = (state_q == StDone) || (state_q == StGap);
  assign field_last = (state_q == StPre) ? PreLast : mdio_field_last(state_q);
  assign frame_end  = fall_tick && (state_q == StData) && (fcnt_q == field_last);

  assign mdio_out = out_q;
  assign mdio_oen = oen_q;

  mdio_clk_gen #(
    .MDC_DIV(MDC_DIV)
  ) u_clk_gen (
    .clk_200m (clk_200m),
    .rst_200m (rst_200m),
    .en       (clk_en),
    .hold     (clk_hold),
    .mdc      (mdc),
    .fall_tick(fall_tick),
    .rise_tick(rise_tick)
  );

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    sr_d        = sr_q;
    rd_d        = rd_q;
    out_d       = out_q;
    oen_d       = oen_q;
    rdata_sh_d  = rdata_sh_q;
    rsp_rdata_d = rsp_rdata_q;
    release_nxt = 1'b0;

    if (state_q == StIdle) begin
      if (accept) begin
        // First preamble bit goes out on the very next cycle.
        state_d    = StPre;
        fcnt_d     = '0;
        rd_d       = host.cmd_rd;
        sr_d       = {MDIO_ST, host.cmd_rd ? MDIO_OP_RD : MDIO_OP_WR,
                      host.cmd_phy_addr, host.cmd_reg_addr,
                      host.cmd_rd ? 2'b11 : MDIO_TA_WR,
                      host.cmd_rd ? {DATA_W{1'b1}} : host.cmd_wdata};
        out_d      = 1'b1;
        oen_d      = 1'b0;
        rdata_sh_d = '0;
      end
    end else if (state_q == StDone) begin
      state_d = StGap;
    end else if (fall_tick) begin
      if (state_q == StGap) begin
        state_d = StIdle;
      end else begin
        if (fcnt_q == field_last) begin
          state_d = mdio_next_state(state_q);
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + 5'd1;
        end

        if (state_d == StDone) begin
          out_d = 1'b1;
          oen_d = 1'b1;
        end else if (state_d == StPre) begin
          out_d = 1'b1;
          oen_d = 1'b0;
        end else begin
          // Reads hand the line to the responder from the first TA bit onward.
          release_nxt = rd_q && ((state_d == StTa) || (state_d == StData));
          out_d       = release_nxt ? 1'b1 : sr_q[31];
          oen_d       = release_nxt;
          sr_d        = {sr_q[30:0], 1'b0};
        end
      end
    end

    if (rise_tick && (state_q == StData)) begin
      rdata_sh_d = {rdata_sh_q[DATA_W-2:0], sync_q[1]};
    end

    if (frame_end) begin
      rsp_rdata_d = rd_q ? rdata_sh_q : '0;
    end
  end

  always_ff @(posedge clk_200m or posedge rst_200m) begin
    if (rst_200m) begin
      state_q     <= StIdle;
      fcnt_q      <= '0;
      sr_q        <= '0;
      rd_q        <= 1'b0;
      out_q       <= 1'b1;
      oen_q       <= 1'b1;
      rdata_sh_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      sr_q        <= sr_d;
      rd_q        <= rd_d;
      out_q       <= out_d;
      oen_q       <= oen_d;
      rdata_sh_q  <= rdata_sh_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // mdio_in is asynchronous to clk_200m.
  always_ff @(posedge clk_200m or posedge rst_200m) begin
    if (rst_200m) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], mdio_in};
    end
  end

`ifdef MDIO_MASTER_TA_CHECK_EN
  logic ta_bad_q;
  logic rsp_err_q;

  always_ff @(posedge clk_200m or posedge rst_200m) begin
    if (rst_200m) begin
      ta_bad_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        ta_bad_q <= 1'b0;
      end else if (rise_tick && rd_q && (state_q == StTa) && (fcnt_q == 5'd1)) begin
        ta_bad_q <= sync_q[1];
      end
      if (frame_end) begin
        rsp_err_q <= rd_q && ta_bad_q;
      end
    end
  end

  assign host.rsp_err = rsp_err_q;
`else
  assign host.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: vector table of frames plus back-to-back, reset and
// short-divider sequences.
`timescale 1ns/1ps
module tb_mdio_master;
  import mdio_pkg::*;

`ifdef MDIO_MASTER_TA_CHECK_EN
  localparam logic ERR_NORESP = 1'b1;
`else
  localparam logic ERR_NORESP = 1'b0;
`endif

  typedef struct {
    logic        rd;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wdata;
    logic        resp_on;
    logic [15:0] resp_data;
    logic [15:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_word;
  } vec_t;

  logic clk_200m = 1'b0;
  logic rst_200m = 1'b1;
  always #5 clk_200m = ~clk_200m;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_200m) cyc <= cyc + 1;

  // Main instance: MDC_DIV=10, PRE_LEN=32.
  mdio_master_if hb ();
  logic mdc, mdio_out, mdio_oen, mdio_in;

  mdio_master #(
    .MDC_DIV(10),
    .PRE_LEN(32)
  ) dut (
    .clk_200m(clk_200m),
    .rst_200m(rst_200m),
    .host    (hb),
    .mdc     (mdc),
    .mdio_out(mdio_out),
    .mdio_oen(mdio_oen),
    .mdio_in (mdio_in)
  );

  // Short-divider instance: MDC_DIV=2, PRE_LEN=1.
  mdio_master_if sb ();
  logic s_mdc, s_out, s_oen, s_in;
  assign s_in = s_oen ? 1'b1 : s_out;

  mdio_master #(
    .MDC_DIV(2),
    .PRE_LEN(1)
  ) dut_s (
    .clk_200m(clk_200m),
    .rst_200m(rst_200m),
    .host    (sb),
    .mdc     (s_mdc),
    .mdio_out(s_out),
    .mdio_oen(s_oen),
    .mdio_in (s_in)
  );

  // Main-instance monitor.
  int   rises = 0, rsp_count = 0, rsp_cyc = 0, rdy_cyc = 0;
  logic prev_mdc = 1'b0, prev_rdy = 1'b1;
  bit   cap_out [0:2047];
  bit   cap_oen [0:2047];

  always @(negedge clk_200m) begin
    if (mdc && !prev_mdc) begin
      cap_out[rises % 2048] <= mdio_out;
      cap_oen[rises % 2048] <= mdio_oen;
      rises <= rises + 1;
    end
    prev_mdc <= mdc;
    if (hb.rsp_valid) begin
      rsp_count <= rsp_count + 1;
      rsp_cyc   <= cyc;
    end
    if (hb.cmd_ready && !prev_rdy) rdy_cyc <= cyc;
    prev_rdy <= hb.cmd_ready;
  end

  // Short-instance monitor.
  int          s_rises = 0, s_rsp_cyc = 0, s_last_rise = 0, s_prev_rise = 0, s_last_fall = 0;
  logic        s_prev_mdc = 1'b0;
  logic [63:0] s_bits = '0;

  always @(negedge clk_200m) begin
    if (s_mdc && !s_prev_mdc) begin
      s_rises     <= s_rises + 1;
      s_prev_rise <= s_last_rise;
      s_last_rise <= cyc;
      s_bits      <= {s_bits[62:0], s_out};
    end
    if (!s_mdc && s_prev_mdc) s_last_fall <= cyc;
    s_prev_mdc <= s_mdc;
    if (sb.rsp_valid) s_rsp_cyc <= cyc;
  end

  // Responder: second TA bit low, then DATA MSB first; otherwise the pull-up.
  int          frame_base = 0;
  logic        resp_on = 1'b0;
  logic [15:0] resp_data = '0;
  int          rk;
  logic        resp_val;

  always_comb begin
    rk       = rises - frame_base;
    resp_val = 1'b1;
    if (resp_on && (rk == 47)) resp_val = 1'b0;
    else if (resp_on && (rk >= 48) && (rk <= 63)) resp_val = resp_data[63-rk];
  end

  assign mdio_in = mdio_oen ? resp_val : mdio_out;

  task automatic step();
    @(negedge clk_200m);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!hb.cmd_ready && n < 4000) begin
      step();
      n++;
    end
    check("idle_timeout", {63'd0, hb.cmd_ready}, 64'd1);
  endtask

  function automatic logic [63:0] frame_bits(input int b, input bit want_oen);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[63-i] = want_oen ? cap_oen[(b + i) % 2048] : cap_out[(b + i) % 2048];
    end
    return r;
  endfunction

  task automatic drive_cmd(input vec_t v);
    hb.cmd_rd       = v.rd;
    hb.cmd_phy_addr = v.phy;
    hb.cmd_reg_addr = v.rg;
    hb.cmd_wdata    = v.wdata;
  endtask

  task automatic check_frame(input string tag, input vec_t v, input int b);
    logic [63:0] mask, exp_oen;
    mask    = v.rd ? ~64'h3FFFF : ~64'h0;
    exp_oen = v.rd ? 64'h3FFFF : 64'h0;
    check({tag, "_out"}, frame_bits(b, 1'b0) & mask, {32'hFFFF_FFFF, v.exp_word} & mask);
    check({tag, "_oen"}, frame_bits(b, 1'b1), exp_oen);
  endtask

  task automatic run_frame(input vec_t v);
    int t0, base_rsp;
    frame_base = rises;
    resp_on    = v.resp_on;
    resp_data  = v.resp_data;
    base_rsp   = rsp_count;
    drive_cmd(v);
    hb.cmd_valid = 1'b1;
    t0 = cyc;
    step();
    hb.cmd_valid = 1'b0;
    wait_idle();
    check("bit_count", 64'(rises - frame_base), 64'd64);
    check("rsp_count", 64'(rsp_count - base_rsp), 64'd1);
    check("rsp_latency", 64'(rsp_cyc - t0), 64'd1281);
    check("ready_latency", 64'(rdy_cyc - t0), 64'd1301);
    check("rsp_rdata", 64'(hb.rsp_rdata), 64'(v.exp_rdata));
    check("rsp_err", 64'(hb.rsp_err), 64'(v.exp_err));
    check_frame("frame", v, frame_base);
  endtask

  vec_t vecs [5];

  initial begin
    int t0, t2, base_rsp, n;

    vecs[0] = '{rd: 1'b0, phy: 5'h05, rg: 5'h1F, wdata: 16'hA5C3, resp_on: 1'b0,
                resp_data: 16'h0, exp_rdata: 16'h0, exp_err: 1'b0, exp_word: 32'h52FE_A5C3};
    vecs[1] = '{rd: 1'b1, phy: 5'h01, rg: 5'h02, wdata: 16'h1234, resp_on: 1'b1,
                resp_data: 16'h004D, exp_rdata: 16'h004D, exp_err: 1'b0,
                exp_word: 32'h6088_0000};
    vecs[2] = '{rd: 1'b1, phy: 5'h01, rg: 5'h02, wdata: 16'h0, resp_on: 1'b0,
                resp_data: 16'h0, exp_rdata: 16'hFFFF, exp_err: ERR_NORESP,
                exp_word: 32'h6088_0000};
    vecs[3] = '{rd: 1'b0, phy: 5'h1F, rg: 5'h00, wdata: 16'hFFFF, resp_on: 1'b0,
                resp_data: 16'h0, exp_rdata: 16'h0, exp_err: 1'b0, exp_word: 32'h5F82_FFFF};
    vecs[4] = '{rd: 1'b1, phy: 5'h10, rg: 5'h15, wdata: 16'h0, resp_on: 1'b1,
                resp_data: 16'hBEEF, exp_rdata: 16'hBEEF, exp_err: 1'b0,
                exp_word: 32'h6854_0000};

    hb.cmd_valid = 1'b0;
    drive_cmd(vecs[0]);
    sb.cmd_valid    = 1'b0;
    sb.cmd_rd       = 1'b0;
    sb.cmd_phy_addr = 5'h05;
    sb.cmd_reg_addr = 5'h1F;
    sb.cmd_wdata    = 16'hA5C3;

    repeat (3) step();
    check("reset_state",
          64'({hb.cmd_ready, hb.busy, hb.rsp_valid, hb.rsp_rdata, hb.rsp_err,
               mdc, mdio_out, mdio_oen}),
          64'({1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1}));
    rst_200m = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // cmd_valid held through a busy write, fields changed: second accept only at cmd_ready.
    frame_base = rises;
    resp_on    = 1'b0;
    base_rsp   = rsp_count;
    drive_cmd(vecs[0]);
    hb.cmd_valid = 1'b1;
    t0 = cyc;
    step();
    drive_cmd(vecs[3]);
    n = 0;
    while (!hb.cmd_ready && n < 4000) begin
      step();
      n++;
    end
    t2 = cyc;
    check("second_accept", 64'(t2 - t0), 64'd1301);
    step();
    hb.cmd_valid = 1'b0;
    wait_idle();
    check("b2b_rsp_count", 64'(rsp_count - base_rsp), 64'd2);
    check("b2b_bit_count", 64'(rises - frame_base), 64'd128);
    check("b2b_second_rsp", 64'(rsp_cyc - t0), 64'd2582);
    check_frame("b2b_first", vecs[0], frame_base);
    check_frame("b2b_second", vecs[3], frame_base + 64);

    // Reset during bit 20 of a read, while mdc is high.
    frame_base = rises;
    resp_on    = 1'b1;
    resp_data  = 16'h004D;
    drive_cmd(vecs[1]);
    hb.cmd_valid = 1'b1;
    step();
    hb.cmd_valid = 1'b0;
    n = 0;
    while ((rises - frame_base) < 21 && n < 2000) begin
      step();
      n++;
    end
    check("pre_reset_mdc", 64'(mdc), 64'd1);
    base_rsp = rsp_count;
    rst_200m = 1'b1;
    #1;
    check("reset_mid_frame", 64'({mdc, mdio_oen, hb.cmd_ready, hb.busy, mdio_out}),
          64'(5'b01101));
    repeat (3) step();
    rst_200m = 1'b0;
    repeat (40) step();
    check("no_rsp_after_reset", 64'(rsp_count - base_rsp), 64'd0);
    run_frame(vecs[0]);

    // Short divider and single-bit preamble on the second instance.
    sb.cmd_valid = 1'b1;
    t0 = cyc;
    step();
    sb.cmd_valid = 1'b0;
    n = 0;
    while (!sb.cmd_ready && n < 400) begin
      step();
      n++;
    end
    check("s_idle_timeout", 64'(sb.cmd_ready), 64'd1);
    check("s_rsp_latency", 64'(s_rsp_cyc - t0), 64'd133);
    check("s_bit_count", 64'(s_rises), 64'd33);
    check("s_mdc_period", 64'(s_last_rise - s_prev_rise), 64'd4);
    check("s_mdc_high", 64'(s_last_fall - s_last_rise), 64'd2);
    check("s_frame_out", {31'd0, s_bits[32:0]}, {31'd0, 1'b1, 32'h52FE_A5C3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Clause-22 MDIO/MDC management initiator. It drives the serial management port of the ADC capture chip from the bench/FPGA side, or from a host controller.
- It serialises register read/write commands into MDIO frames, generates MDC and captures read data returned by the chip's MDIO responder.
- It sits between a simple command/response handshake and the MDC/MDIO pads.

Parameters:
- MDC_DIV, 10, half-period of MDC in clk_200m cycles. Range 2..255. Default gives MDC = 10 MHz.
- PRE_LEN, 32, preamble length in bits. Range 1..32.

Ports:
- clk_200m  input  1  system clock; the only clock.
- rst_200m  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  master idle; command accepted when cmd_valid & cmd_ready.
- cmd_rd  input  1  1 = read, 0 = write.
- cmd_phy_addr  input  5  PHY address.
- cmd_reg_addr  input  5  register address.
- cmd_wdata  input  16  write data.
- rsp_valid  output  1  one-cycle pulse when a frame completes.
- rsp_rdata  output  16  read data; 0 for writes.
- rsp_err  output  1  read turnaround error (see Optional Feature).
- busy  output  1  frame in progress.
- mdc  output  1  management clock.
- mdio_out  output  1  serial data to pad.
- mdio_oen  output  1  pad output enable, active-low (0 = drive).
- mdio_in  input  1  serial data from pad, asynchronous.

Behaviour:
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mdc=0, mdio_out=1, mdio_oen=1.
- Reset is asynchronous, active-high; clk_200m is the only clock.
- Frame, MSB first: PRE_LEN ones, ST=01, OP (read 10 / write 01), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0]. Length N = PRE_LEN+32 bits.
- TA on write: master drives 1,0. TA on read: master releases (mdio_oen=1) from the first TA bit through the end of DATA.
- Commands are captured into a shift register on acceptance at cycle T.
- Bit period = 2*MDC_DIV cycles:
  - Each period starts at cycle T+1+k*2*MDC_DIV.
  - mdio_out/mdio_oen update on the first cycle of the period (MDC falling edge).
  - mdc is low for MDC_DIV cycles, then high for MDC_DIV cycles.
- mdio_in passes through a 2-flop synchroniser. Its output is sampled in the cycle where mdc goes 0→1; that sample is the value of the current bit.
- Read DATA bits shift in MSB first.
- rsp_valid pulses at cycle T+1+N*2*MDC_DIV. rsp_rdata/rsp_err update in the same cycle and hold until the next rsp_valid.
- Idle bit follows: one bit period with mdc=0, mdio_oen=1, mdio_out=1. cmd_ready rises at T+1+(N+1)*2*MDC_DIV.
- FSM states: IDLE → PRE → ST → OP → PHYAD → REGAD → TA → DATA → DONE → GAP → IDLE.
  - A bit counter drives transitions at bit-period boundaries.
  - DONE lasts one cycle (rsp_valid).
- busy = !cmd_ready.
- cmd_valid while cmd_ready=0 is ignored; command inputs are don't-care outside the accept cycle.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); no rsp_valid; the partial frame is abandoned.
- MDC never produces a high phase shorter than MDC_DIV cycles, including at frame start and after reset.

Optional Feature:
- Macro: MDIO_MASTER_TA_CHECK_EN.
- Defined: on reads, the synchronised mdio_in sampled at the second TA bit must be 0 (responder driving). If it is 1, rsp_err=1 with that rsp_valid. The frame still completes and rsp_rdata holds the sampled DATA, typically 0xFFFF with a pull-up. rsp_err=0 for writes.
- Undefined: rsp_err is tied 0 and the TA sample logic is absent.

Decomposition:
- Shared package mdio_pkg:
  - MDIO_ST=2'b01, MDIO_OP_RD=2'b10, MDIO_OP_WR=2'b01, MDIO_TA_WR=2'b10.
  - Field widths (PHYAD 5, REGAD 5, DATA 16).
  - FSM state enum.
- Sub-module mdio_clk_gen (parameter MDC_DIV):
  - Divider counter producing mdc, fall_tick (period start) and rise_tick (sample point).
  - Enabled while busy; held low when idle.

Test Plan:
- Write: phy 5'h05, reg 5'h1F, data 16'hA5C3, MDC_DIV=10 → mdio_out sampled on 64 mdc rises equals 32×1, 01, 01, 00101, 11111, 10, 1010010111000011. mdio_oen=0 throughout. rsp_valid at T+1281, rsp_rdata=0, cmd_ready at T+1301.
- Read: phy 1, reg 2, responder model drives TA 0 then 16'h004D → rsp_rdata=16'h004D, rsp_err=0. mdio_oen=1 from bit 46 through 63.
- Read with no responder (pull-up 1), macro defined → rsp_rdata=16'hFFFF, rsp_err=1. Macro undefined → rsp_err=0.
- cmd_valid held high during a busy write with different fields → second command accepted only at cmd_ready. Exactly two frames observed, the second starting T+1301+1.
- rst_200m asserted at bit 20 of a read → mdc=0, mdio_oen=1, cmd_ready=1 within the same cycle; no rsp_valid. A following write completes correctly.
- MDC_DIV=2, PRE_LEN=1 → mdc period 4 cycles, 50% duty. Frame of 33 bits; rsp_valid at T+133.
